// File: rtl/cronometro_ctrl.sv
// Stopwatch control: button synchronizers and debouncers, the free-running
// time-base prescaler, and the IDLE/RUN/LAP/STOP FSM driving the counter datapath.
module cronometro_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic       ms_tick,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(DEB_TICKS + 1);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DLAST = CW'(DEB_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic          clr_nxt;
  logic          run_nxt;
  logic          tick_nxt;

  logic [PW-1:0] pcnt;
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    ev;
  logic [CW-1:0] dcnt [2];

  // Bit 0 carries start_stop, bit 1 carries lap_reset throughout.
  assign raw = {lap_reset, start_stop};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A clear cycle also suppresses a tick that would otherwise have landed on it.
  assign tick_nxt = (pcnt == PLAST) && !count_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      ms_tick <= 1'b0;
    end else begin
      ms_tick <= tick_nxt;
      if (count_clr || (pcnt == PLAST)) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // The stable-count only advances on ticks while the input disagrees with db.
  always_ff @(posedge clk) begin
    if (rst) begin
      db      <= '0;
      ev      <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      ev <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (ms_tick) begin
          if (dcnt[i] == DLAST) begin
            dcnt[i] <= '0;
            db[i]   <= sync2[i];
            ev[i]   <= sync2[i];
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    clr_nxt   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (ev[0]) nxt_state = RUN;
      end
      RUN: begin
        if (ev[0])      nxt_state = STOP;
        else if (ev[1]) nxt_state = LAP;
      end
      LAP: begin
        if (ev[0])      nxt_state = STOP;
        else if (ev[1]) nxt_state = RUN;
      end
      STOP: begin
        if (ev[0]) begin
          nxt_state = RUN;
        end else if (ev[1]) begin
          nxt_state = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    run_nxt = (nxt_state == RUN) || (nxt_state == LAP);
  end

  // Outputs are registered from next-cycle values so each one is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      count_clr <= 1'b1;
      count_en  <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      count_clr <= clr_nxt;
      count_en  <= tick_nxt && run_nxt;
      disp_hold <= (nxt_state == LAP);
      running   <= run_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Randomized self-checking bench for cronometro_ctrl: a cycle-level behavioural
// model of the stopwatch rules is compared against the DUT on every cycle.
module tb_cronometro_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DEB_TICKS = 2;
  localparam int DIV       = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       lap_reset;
  logic       ms_tick;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic       running;
  logic [1:0] state;

  int checks   = 0;
  int errors   = 0;
  bit check_en = 0;

  cronometro_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DEB_TICKS(DEB_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .lap_reset (lap_reset),
    .ms_tick   (ms_tick),
    .count_en  (count_en),
    .count_clr (count_clr),
    .disp_hold (disp_hold),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Transition table indexed by [state][event], event 0 = none, 1 = lap press,
  // 2 = start press (start wins when both arrive together).
  int trans [4][3] = '{'{0, 0, 1}, '{1, 2, 3}, '{2, 1, 3}, '{3, 0, 1}};

  // Model state: current-cycle values of the observable behaviour.
  int m_state = 0;
  int age     = 0;
  int m_cnt [2];
  bit m_tick  = 0;
  bit m_clr   = 0;
  bit m_db [2];
  bit m_ev [2];
  bit hist [2][2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ticks fall every DIV cycles counted from the last clear cycle (age 0).
  always @(posedge clk) begin
    int  code;
    int  nstate;
    bit  nclr;
    bit  ntick;
    bit  s;
    bit  raw [2];
    raw[0] = start_stop;
    raw[1] = lap_reset;
    if (rst) begin
      m_state = 0;
      m_clr   = 1;
      m_tick  = 0;
      age     = 0;
      for (int i = 0; i < 2; i++) begin
        m_db[i]    = 0;
        m_cnt[i]   = 0;
        m_ev[i]    = 0;
        hist[i][0] = 0;
        hist[i][1] = 0;
      end
    end else begin
      code   = m_ev[0] ? 2 : (m_ev[1] ? 1 : 0);
      nstate = trans[m_state][code];
      nclr   = (m_state == 3) && (nstate == 0);
      ntick  = !m_clr && (age > 0) && ((age % DIV) == 0);
      age    = nclr ? 0 : age + 1;
      for (int i = 0; i < 2; i++) begin
        s       = hist[i][1];
        m_ev[i] = 0;
        if (s == m_db[i]) begin
          m_cnt[i] = 0;
        end else if (m_tick) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB_TICKS) begin
            m_db[i]  = s;
            m_cnt[i] = 0;
            m_ev[i]  = s;
          end
        end
        hist[i][1] = hist[i][0];
        hist[i][0] = raw[i];
      end
      m_state = nstate;
      m_clr   = nclr;
      m_tick  = ntick;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("ms_tick",   ms_tick,   m_tick);
      checkOutput("count_en",  count_en,  m_tick && (m_state == 1 || m_state == 2));
      checkOutput("count_clr", count_clr, m_clr);
      checkOutput("disp_hold", disp_hold, m_state == 2);
      checkOutput("running",   running,   m_state == 1 || m_state == 2);
      checkOutput("state",     state,     m_state);
    end
  end

  task automatic applyStimulus(input logic ss, input logic lr, input int n,
                               output int changes, output int en_pulses, output int clr_pulses);
    logic [1:0] prev;
    start_stop = ss;
    lap_reset  = lr;
    changes    = 0;
    en_pulses  = 0;
    clr_pulses = 0;
    prev       = state;
    repeat (n) begin
      @(negedge clk);
      if (state !== prev) changes++;
      prev = state;
      if (count_en)  en_pulses++;
      if (count_clr) clr_pulses++;
    end
  endtask

  initial begin
    int ch;
    int en;
    int cl;
    int n;
    int total_ch;
    rst        = 1'b1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    @(negedge clk);
    check_en = 1;
    checkOutput("reset_count_clr", count_clr, 1);
    checkOutput("reset_state",     state,     0);
    checkOutput("reset_running",   running,   0);
    repeat (2) @(negedge clk);

    // Edge 1 of this loop is the release edge; the first tick appears on the
    // 10th edge after it.
    rst = 1'b0;
    n   = 0;
    while (n < 30 && ms_tick !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_tick_edges", n, 11);
    checkOutput("clr_after_reset", count_clr, 0);

    applyStimulus(1'b1, 1'b0, 40, ch, en, cl);
    checkOutput("start_state", state, 1);
    checkOutput("start_events", ch, 1);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);
    checkOutput("release_no_event", ch, 0);
    checkOutput("run_en_pulses", en, 4);

    applyStimulus(1'b0, 1'b1, 40, ch, en, cl);
    checkOutput("lap_state", state, 2);
    checkOutput("lap_hold", disp_hold, 1);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);
    checkOutput("lap_en_pulses", en, 4);
    applyStimulus(1'b0, 1'b1, 40, ch, en, cl);
    checkOutput("unlap_state", state, 1);
    checkOutput("unlap_hold", disp_hold, 0);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);

    applyStimulus(1'b1, 1'b0, 40, ch, en, cl);
    checkOutput("stop_state", state, 3);
    applyStimulus(1'b0, 1'b0, 50, ch, en, cl);
    checkOutput("stop_no_en", en, 0);
    applyStimulus(1'b0, 1'b1, 40, ch, en, cl);
    checkOutput("clear_state", state, 0);
    checkOutput("clear_pulse", cl, 1);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);

    total_ch = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus((k % 2) == 0, 1'b0, 7, ch, en, cl);
      total_ch += ch;
    end
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);
    total_ch += ch;
    checkOutput("bounce_no_event", total_ch, 0);
    checkOutput("bounce_state", state, 0);

    applyStimulus(1'b1, 1'b0, 40, ch, en, cl);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);
    applyStimulus(1'b1, 1'b1, 40, ch, en, cl);
    checkOutput("both_state", state, 3);
    checkOutput("both_hold", disp_hold, 0);
    checkOutput("both_single_step", ch, 1);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);

    applyStimulus(1'b1, 1'b0, 40, ch, en, cl);
    applyStimulus(1'b0, 1'b0, 40, ch, en, cl);
    applyStimulus(1'b0, 1'b1, 40, ch, en, cl);
    checkOutput("pre_rst_lap", state, 2);
    applyStimulus(1'b0, 1'b0, 20, ch, en, cl);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midlap_rst_state", state, 0);
    checkOutput("midlap_rst_hold", disp_hold, 0);
    checkOutput("midlap_rst_clr", count_clr, 1);
    checkOutput("midlap_rst_running", running, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        rst = 1'b0;
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 45)), ch, en, cl);
      end
    end
    applyStimulus(1'b0, 1'b0, 10, ch, en, cl);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
